// File: rtl/axiuart_uart_pkg.sv
// Shared types and constants for the oversampled UART receiver.
package axiuart_uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);

  localparam logic [TICK_W-1:0] MID_TICK_LO  = TICK_W'(7);
  localparam logic [TICK_W-1:0] MID_TICK_MID = TICK_W'(8);
  localparam logic [TICK_W-1:0] MID_TICK_HI  = TICK_W'(9);
  localparam logic [TICK_W-1:0] LAST_TICK    = TICK_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; head reads as zero when empty.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     push_ok,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign push_ok = push & (~full | pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x oversampled UART receiver: synchroniser, tick generator, framing FSM,
// RX byte FIFO and hysteretic RTS flow control.
module uart_rx_oversample
  import axiuart_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned RTS_MARGIN = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         uart_rx,
  input  logic [15:0]                  baud_divisor,
  input  logic                         rx_ready,
  output logic [7:0]                   rx_data,
  output logic                         rx_valid,
  output logic                         rx_error,
  output logic                         byte_received,
  output logic                         rx_overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         uart_rts_n
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic rx_meta, rx_sync, rx_prev, fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall = rx_prev & ~rx_sync;

  rx_state_t          state;
  logic [15:0]        div_lat, div_cnt, tick_limit;
  logic               tick, start_edge;

  assign start_edge = (state == IDLE) && fall;

  always_comb begin
    tick_limit = '0;
    if (div_lat > 16'd1) tick_limit = div_lat - 16'd1;
  end

  assign tick = (div_cnt == tick_limit);

  // Divisor is latched only at wrap so a change never produces a short tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      div_lat <= '0;
    end else if (start_edge) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      div_lat <= baud_divisor;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_cnt;
  logic              s_lo, s_mid, vote, at_vote;
  logic [7:0]        shreg;
  logic              push, push_ok;

  assign vote    = maj3(s_lo, s_mid, rx_sync);
  assign at_vote = tick && (tick_cnt == MID_TICK_HI);
  assign push    = (state == STOP) && at_vote && vote;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      s_lo          <= 1'b1;
      s_mid         <= 1'b1;
      shreg         <= '0;
      rx_error      <= 1'b0;
      byte_received <= 1'b0;
      rx_overflow   <= 1'b0;
    end else begin
      rx_error      <= 1'b0;
      byte_received <= push_ok;
      rx_overflow   <= push & ~push_ok;
      if (tick) begin
        tick_cnt <= tick_cnt + TICK_W'(1);
        if (tick_cnt == MID_TICK_LO)  s_lo  <= rx_sync;
        if (tick_cnt == MID_TICK_MID) s_mid <= rx_sync;
      end
      case (state)
        IDLE: begin
          if (fall) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= START;
          end
        end
        START: begin
          if (at_vote && vote) state <= IDLE;
          else if (tick && tick_cnt == LAST_TICK) state <= DATA;
        end
        DATA: begin
          if (at_vote) shreg <= {vote, shreg[7:1]};
          if (tick && tick_cnt == LAST_TICK) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (at_vote) begin
            if (vote) begin
              state <= IDLE;
            end else begin
              rx_error <= 1'b1;
              state    <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic fifo_empty;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push    (push),
    .din     (shreg),
    .pop     (rx_ready),
    .dout    (rx_data),
    .empty   (fifo_empty),
    .push_ok (push_ok),
    .count   (fifo_count)
  );

  assign rx_valid = ~fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uart_rts_n <= 1'b1;
    end else if (fifo_count >= CNT_W'(FIFO_DEPTH - RTS_MARGIN)) begin
      uart_rts_n <= 1'b1;
    end else if (fifo_count <= CNT_W'(RTS_MARGIN)) begin
      uart_rts_n <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: serial frames driven bit by bit, FIFO/RTS checked.
`timescale 1ns/1ps
module tb_uart_rx_oversample;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        uart_rx = 1'b1;
  logic [15:0] baud_divisor = 16'd68;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_error, byte_received, rx_overflow, uart_rts_n;
  logic [4:0]  fifo_count;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cnt_recv = 0, cnt_err = 0, cnt_ovf = 0;
  int b_recv, b_err, b_ovf;
  int bitc;
  logic [7:0] partial;

  uart_rx_oversample #(
    .FIFO_DEPTH (16),
    .RTS_MARGIN (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .uart_rx       (uart_rx),
    .baud_divisor  (baud_divisor),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_error      (rx_error),
    .byte_received (byte_received),
    .rx_overflow   (rx_overflow),
    .fifo_count    (fifo_count),
    .uart_rts_n    (uart_rts_n)
  );

  always #4 clk = ~clk;

  always @(negedge clk) begin
    if (byte_received) cnt_recv++;
    if (rx_error)      cnt_err++;
    if (rx_overflow)   cnt_ovf++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    uart_rx = b;
    wait_cycles(bitc);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_b);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    wait_cycles(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    bitc = 16 * 68;
    wait_cycles(5);
    check("rst_rx_data",       32'(rx_data),       32'h0);
    check("rst_rx_valid",      32'(rx_valid),      32'h0);
    check("rst_rx_error",      32'(rx_error),      32'h0);
    check("rst_byte_received", 32'(byte_received), 32'h0);
    check("rst_rx_overflow",   32'(rx_overflow),   32'h0);
    check("rst_fifo_count",    32'(fifo_count),    32'h0);
    check("rst_rts_n",         32'(uart_rts_n),    32'h1);
    rst = 1'b1;
    wait_cycles(1);
    check("rts_after_release", 32'(uart_rts_n), 32'h0);
    wait_cycles(200);

    // T1: 0xA5 at ~115200 baud
    b_recv = cnt_recv;
    send_frame(8'hA5, 1'b1);
    wait_cycles(4);
    check("t1_recv_pulses", 32'(cnt_recv - b_recv), 32'd1);
    check("t1_rx_valid",    32'(rx_valid),   32'h1);
    check("t1_fifo_count",  32'(fifo_count), 32'd1);
    pop_check("t1_rx_data", 8'hA5);
    check("t1_valid_after_pop", 32'(rx_valid), 32'h0);

    baud_divisor = 16'd4;
    bitc = 16 * 4;
    wait_cycles(100);

    // T2: short glitch
    b_recv = cnt_recv; b_err = cnt_err;
    uart_rx = 1'b0;
    wait_cycles(16);
    uart_rx = 1'b1;
    wait_cycles(3 * bitc);
    check("t2_recv_pulses", 32'(cnt_recv - b_recv), 32'd0);
    check("t2_err_pulses",  32'(cnt_err - b_err),   32'd0);
    check("t2_fifo_count",  32'(fifo_count),        32'd0);

    // T3: framing error followed by a held-low line
    b_recv = cnt_recv; b_err = cnt_err;
    send_frame(8'h3C, 1'b0);
    wait_cycles(3 * bitc);
    uart_rx = 1'b1;
    wait_cycles(2 * bitc);
    check("t3_err_pulses",  32'(cnt_err - b_err),   32'd1);
    check("t3_recv_pulses", 32'(cnt_recv - b_recv), 32'd0);
    check("t3_fifo_count",  32'(fifo_count),        32'd0);
    send_frame(8'h55, 1'b1);
    wait_cycles(4);
    check("t3_recv_after", 32'(cnt_recv - b_recv), 32'd1);
    pop_check("t3_rx_data", 8'h55);

    // T4: fill, overflow, RTS hysteresis
    b_recv = cnt_recv; b_ovf = cnt_ovf;
    for (int i = 0; i < 11; i++) begin
      send_frame(8'(i), 1'b1);
      wait_cycles(8);
    end
    check("t4_rts_at_11",   32'(uart_rts_n), 32'h0);
    check("t4_count_11",    32'(fifo_count), 32'd11);
    send_frame(8'd11, 1'b1);
    wait_cycles(8);
    check("t4_rts_at_12",   32'(uart_rts_n), 32'h1);
    check("t4_count_12",    32'(fifo_count), 32'd12);
    for (int i = 12; i < 16; i++) begin
      send_frame(8'(i), 1'b1);
      wait_cycles(8);
    end
    check("t4_ovf_at_16",   32'(cnt_ovf - b_ovf), 32'd0);
    check("t4_count_16",    32'(fifo_count),      32'd16);
    send_frame(8'h10, 1'b1);
    wait_cycles(8);
    check("t4_ovf_at_17",   32'(cnt_ovf - b_ovf),   32'd1);
    check("t4_recv_pulses", 32'(cnt_recv - b_recv), 32'd16);
    check("t4_count_full",  32'(fifo_count),        32'd16);
    for (int i = 0; i < 16; i++) begin
      pop_check("t4_pop_data", 8'(i));
      if (i == 10) begin
        wait_cycles(1);
        check("t4_rts_hold_5", 32'(uart_rts_n), 32'h1);
      end
      if (i == 11) begin
        wait_cycles(1);
        check("t4_count_4",    32'(fifo_count), 32'd4);
        check("t4_rts_fall_4", 32'(uart_rts_n), 32'h0);
      end
    end
    check("t4_empty_valid", 32'(rx_valid), 32'h0);
    rx_ready = 1'b1;
    wait_cycles(1);
    rx_ready = 1'b0;
    check("t4_pop_empty_count", 32'(fifo_count), 32'd0);

    // T5: back-to-back frames, then divisor 1
    b_recv = cnt_recv;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_cycles(4);
    check("t5_recv_pulses", 32'(cnt_recv - b_recv), 32'd2);
    check("t5_fifo_count",  32'(fifo_count),        32'd2);
    pop_check("t5_first",  8'h00);
    pop_check("t5_second", 8'hFF);
    baud_divisor = 16'd1;
    bitc = 16;
    wait_cycles(20);
    b_recv = cnt_recv;
    send_frame(8'h81, 1'b1);
    wait_cycles(4);
    check("t5_div1_recv", 32'(cnt_recv - b_recv), 32'd1);
    pop_check("t5_div1_data", 8'h81);

    // T6: reset during data bit 3
    baud_divisor = 16'd4;
    bitc = 64;
    wait_cycles(40);
    send_frame(8'h5A, 1'b1);
    wait_cycles(4);
    check("t6_pre_valid", 32'(rx_valid), 32'h1);
    partial = 8'h96;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(partial[i]);
    uart_rx = partial[3];
    wait_cycles(32);
    rst = 1'b0;
    wait_cycles(2);
    check("t6_rst_rx_data",  32'(rx_data),       32'h0);
    check("t6_rst_valid",    32'(rx_valid),      32'h0);
    check("t6_rst_count",    32'(fifo_count),    32'd0);
    check("t6_rst_rts",      32'(uart_rts_n),    32'h1);
    check("t6_rst_error",    32'(rx_error),      32'h0);
    check("t6_rst_recv",     32'(byte_received), 32'h0);
    check("t6_rst_overflow", 32'(rx_overflow),   32'h0);
    uart_rx = 1'b1;
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(2 * bitc);
    b_recv = cnt_recv;
    send_frame(8'h81, 1'b1);
    wait_cycles(4);
    check("t6_recv_pulses", 32'(cnt_recv - b_recv), 32'd1);
    check("t6_fifo_count",  32'(fifo_count),        32'd1);
    pop_check("t6_rx_data", 8'h81);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
